// File: rtl/fib_table_if.sv
// Client side of the forwarding-table port: address, active-low strobes and data.
// Strobe protocol: a request is presented when ft_rd_n or ft_wr_n is 0 and is
// always accepted in that same cycle (there is no ready/backpressure). Read data
// appears on ft_rdata the following cycle and is held until the next read.
interface fib_table_if #(
  parameter int FIB_ASZ      = 8,
  parameter int FIB_ENTRY_SZ = 54
);
  logic [FIB_ASZ-1:0]      ft_addr;
  logic                    ft_rd_n;
  logic                    ft_wr_n;
  logic [FIB_ENTRY_SZ-1:0] ft_wdata;
  logic [FIB_ENTRY_SZ-1:0] ft_rdata;

  modport master (
    output ft_addr, ft_rd_n, ft_wr_n, ft_wdata,
    input  ft_rdata
  );

  modport slave (
    input  ft_addr, ft_rd_n, ft_wr_n, ft_wdata,
    output ft_rdata
  );
endinterface

// File: rtl/fib_table_aging.sv
// Forwarding-table storage with a background sweeper that decrements entry ages
// on a fixed period, using only port cycles the client leaves idle.
module fib_table_aging #(
  parameter int FIB_ENTRIES = 256,
  parameter int FIB_ASZ     = 8,
  parameter int AGE_SZ      = 4,
  parameter int PORT_SZ     = 2,
  parameter int AGE_PERIOD  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  fib_table_if.slave ft,
  input  logic       age_enable,
  output logic       sweep_busy,
  output logic       sweep_done,
  output logic       age_evict,
  output logic [2:0] dbg_state_o
);
  localparam int FIB_ENTRY_SZ = 48 + AGE_SZ + PORT_SZ;
  localparam int PRESC_SZ     = (AGE_PERIOD > 2) ? $clog2(AGE_PERIOD) : 1;
  localparam logic [PRESC_SZ-1:0] PRESC_LAST = PRESC_SZ'(AGE_PERIOD - 1);
  localparam logic [FIB_ASZ-1:0]  PTR_LAST   = FIB_ASZ'(FIB_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RD   = 3'b010,
    S_WR   = 3'b100
  } state_e;

  logic [FIB_ENTRY_SZ-1:0] mem_q [FIB_ENTRIES];

  state_e                  state_q, state_d;
  logic [FIB_ASZ-1:0]      ptr_q, ptr_d;
  logic [FIB_ENTRY_SZ-1:0] sw_data_q, sw_data_d;
  logic                    abort_q, abort_d;
  logic                    pend_q, pend_d;
  logic [PRESC_SZ-1:0]     presc_q, presc_d;
  logic                    done_q, done_d;
  logic                    evict_q, evict_d;
  logic [FIB_ENTRY_SZ-1:0] rdata_q;

  logic                    client_cyc;
  logic                    tick;
  logic                    pend_clr;
  logic                    sw_we;
  logic [AGE_SZ-1:0]       sw_age;
  logic [FIB_ENTRY_SZ-1:0] sw_wdata;

  assign client_cyc = !ft.ft_rd_n || !ft.ft_wr_n;
  assign tick       = age_enable && (presc_q == PRESC_LAST);
  assign sw_age     = sw_data_q[PORT_SZ +: AGE_SZ];
  assign sw_wdata   = {sw_data_q[FIB_ENTRY_SZ-1:PORT_SZ+AGE_SZ], sw_age - 1'b1,
                       sw_data_q[PORT_SZ-1:0]};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sw_data_d = sw_data_q;
    abort_d   = abort_q;
    done_d    = 1'b0;
    evict_d   = 1'b0;
    sw_we     = 1'b0;
    pend_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_clr = 1'b1;
          ptr_d    = '0;
          state_d  = S_RD;
        end
      end
      S_RD: begin
        if (!client_cyc) begin
          sw_data_d = mem_q[ptr_q];
          abort_d   = 1'b0;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        if (client_cyc) begin
          // A client write to the entry we hold makes our copy stale.
          if (!ft.ft_wr_n && (ft.ft_addr == ptr_q)) abort_d = 1'b1;
        end else begin
          sw_we   = !abort_q && (sw_age != '0);
          evict_d = sw_we && (sw_age == AGE_SZ'(1));
          if (ptr_q == PTR_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Consuming a pending tick wins over a new one arriving in the same cycle.
    if (pend_clr)  pend_d = 1'b0;
    else if (tick) pend_d = 1'b1;
    else           pend_d = pend_q;

    if (!age_enable)              presc_d = presc_q;
    else if (presc_q == PRESC_LAST) presc_d = '0;
    else                          presc_d = presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      sw_data_q <= '0;
      abort_q   <= 1'b0;
      pend_q    <= 1'b0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      evict_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sw_data_q <= sw_data_d;
      abort_q   <= abort_d;
      pend_q    <= pend_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      evict_q   <= evict_d;
      if (!ft.ft_rd_n) rdata_q <= mem_q[ft.ft_addr];
    end
  end

  // Table contents survive reset; a sweeper writeback in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!ft.ft_wr_n)            mem_q[ft.ft_addr] <= ft.ft_wdata;
    else if (sw_we && !reset)   mem_q[ptr_q]      <= sw_wdata;
  end

  assign ft.ft_rdata = rdata_q;
  assign sweep_busy  = (state_q != S_IDLE);
  assign sweep_done  = done_q;
  assign age_evict   = evict_q;
  assign dbg_state_o = state_q;
endmodule
